// File: rtl/coherent_mem_arbiter.sv
// coherent_mem_arbiter: round-robin arbiter between CPUS caches and one RAM port,
// with snoop broadcast, invalidation and cache-to-cache transfer plus RAM write-back.
module coherent_mem_arbiter #(
    parameter int CPUS  = 4,
    parameter int WORDS = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CPUS-1:0]   iREN,
    input  logic [31:0]       iaddr       [CPUS],
    input  logic [CPUS-1:0]   dREN,
    input  logic [CPUS-1:0]   dWEN,
    input  logic [31:0]       daddr       [CPUS],
    input  logic [31:0]       dstore      [CPUS],
    input  logic [CPUS-1:0]   cctrans,
    input  logic [CPUS-1:0]   ccwrite,
    output logic [CPUS-1:0]   iwait,
    output logic [CPUS-1:0]   dwait,
    output logic [31:0]       iload       [CPUS],
    output logic [31:0]       dload       [CPUS],
    output logic [CPUS-1:0]   ccwait,
    output logic [CPUS-1:0]   ccinv,
    output logic [31:0]       ccsnoopaddr [CPUS],
    output logic              ramREN,
    output logic              ramWEN,
    output logic [31:0]       ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic [1:0]        ramstate
);
    localparam int WB = $clog2(WORDS);
    localparam int CW = (WB > 0) ? WB : 1;
    localparam int PW = $clog2(CPUS);
    localparam logic [1:0] ACCESS = 2'd2;

    typedef enum logic [2:0] {IDLE, SNOOP, C2C, RAMRD, RAMWR, IFETCH} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, req_q, req_d, src_q, src_d, gnt, k, nxt;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            rdx_q, rdx_d, found, hit, adv, last;
    logic [CPUS-1:0] elig;
    logic [31:0]     base, word_a;

    assign elig   = dWEN | (dREN & cctrans) | iREN;
    assign base   = {daddr[req_q][31:WB+2], {(WB+2){1'b0}}};
    assign word_a = base | (32'(wcnt_q) << 2);
    assign nxt    = (req_q == PW'(CPUS-1)) ? '0 : req_q + 1'b1;
    assign last   = wcnt_q == CW'(WORDS-1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            req_q    <= '0;
            src_q    <= '0;
            wcnt_q   <= '0;
            rdx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= req_d;
            src_q    <= src_d;
            wcnt_q   <= wcnt_d;
            rdx_q    <= rdx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        req_d    = req_q;
        src_d    = src_q;
        wcnt_d   = wcnt_q;
        rdx_d    = rdx_q;
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int j = 0; j < CPUS; j++) begin
            iload[j]       = '0;
            dload[j]       = '0;
            ccsnoopaddr[j] = '0;
        end
        found = 1'b0;
        hit   = 1'b0;
        adv   = 1'b0;
        gnt   = '0;
        k     = '0;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < CPUS; i++) begin
                    k = PW'((int'(rr_ptr_q) + i) % CPUS);
                    if (!found && elig[k]) begin
                        found = 1'b1;
                        gnt   = k;
                    end
                end
                if (found) begin
                    req_d   = gnt;
                    rdx_d   = ccwrite[gnt];
                    state_d = dWEN[gnt] ? RAMWR : (dREN[gnt] && cctrans[gnt]) ? SNOOP : IFETCH;
                end
            end
            SNOOP: begin
                for (int j = 0; j < CPUS; j++) begin
                    if (j != int'(req_q)) begin
                        ccwait[j]      = 1'b1;
                        ccinv[j]       = rdx_q;
                        ccsnoopaddr[j] = base;
                        if (cctrans[j] && !hit) begin
                            hit   = 1'b1;
                            src_d = PW'(j);
                        end
                    end
                end
                state_d = hit ? C2C : RAMRD;
            end
            C2C: begin
                ccwait[src_q]      = 1'b1;
                ccinv[src_q]       = rdx_q;
                ccsnoopaddr[src_q] = word_a;
                ramWEN             = 1'b1;
                ramaddr            = word_a;
                ramstore           = dstore[src_q];
                dload[req_q]       = dstore[src_q];
                adv                = 1'b1;
            end
            RAMRD: begin
                ramREN       = 1'b1;
                ramaddr      = word_a;
                dload[req_q] = ramload;
                adv          = 1'b1;
            end
            RAMWR: begin
                ramWEN   = 1'b1;
                ramaddr  = word_a;
                ramstore = dstore[req_q];
                adv      = 1'b1;
            end
            IFETCH: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr[req_q];
                iload[req_q] = ramload;
                if (ramstate == ACCESS) begin
                    iwait[req_q] = 1'b0;
                    state_d      = IDLE;
                    rr_ptr_d     = nxt;
                end
            end
            default: state_d = IDLE;
        endcase
        // Block transfers advance one word per ACCESS; other RAM states just hold.
        if (adv && ramstate == ACCESS) begin
            dwait[req_q] = 1'b0;
            wcnt_d       = last ? '0 : wcnt_q + 1'b1;
            if (last) begin
                state_d  = IDLE;
                rr_ptr_d = nxt;
            end
        end
    end
endmodule

// File: doc/coherent_mem_arbiter.md
# coherent_mem_arbiter

N-CPU successor to the two-CPU memory controller: arbitrates instruction fetches, cache write-backs and coherent block reads between `CPUS` caches and one shared RAM port. It broadcasts snoops to every non-requesting cache, invalidates on read-exclusive, and supports cache-to-cache transfer with a simultaneous write-back to RAM. Block size (`WORDS`) and CPU count are parameters. Fairness comes from a round-robin grant pointer. The block sits between the per-CPU caches and the RAM model.

## Interface
- `CPUS`, 4: number of cache pairs; must be ≥2.
- `WORDS`, 2: words per data block; power of 2, 1..8. `WB = log2(WORDS)`.
- `CLK` in, 1: clock.
- `nRST` in, 1: asynchronous, active-low reset.
- `iREN` in, [CPUS]: instruction fetch request.
- `iaddr` in, [CPUS][32]: instruction word address.
- `dREN` in, [CPUS]: data block read (miss).
- `dWEN` in, [CPUS]: data block write-back (eviction).
- `daddr` in, [CPUS][32]: data address; block base taken as `daddr[31:WB+2]`.
- `dstore` in, [CPUS][32]: write-back word, or snoop-supplied word.
- `cctrans` in, [CPUS]: as requester, qualifies `dREN` as coherent. As snoopee, means "I hold the block dirty and supply it".
- `ccwrite` in, [CPUS]: requester intends to write (BusRdX).
- `iwait` out, [CPUS]: 0 for one cycle when `iload` is valid.
- `dwait` out, [CPUS]: 0 for one cycle per completed word.
- `iload` out, [CPUS][32]: fetched instruction.
- `dload` out, [CPUS][32]: read word.
- `ccwait` out, [CPUS]: snoopee is stalled and must service the snoop.
- `ccinv` out, [CPUS]: invalidate the line at `ccsnoopaddr`.
- `ccsnoopaddr` out, [CPUS][32]: snoop or word address.
- `ramREN` out, 1: RAM read strobe.
- `ramWEN` out, 1: RAM write strobe.
- `ramaddr` out, 32: RAM word address.
- `ramstore` out, 32: RAM write data.
- `ramload` in, 32: RAM read data.
- `ramstate` in, 2: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- **Reset values.** All `iwait`/`dwait` = 1. All other outputs = 0. State IDLE. `rr_ptr` = 0, `wcnt` = 0, `req` = 0, `src` = 0.
- **Eligibility.** CPU k is eligible if `dWEN[k]`, or `dREN[k]&cctrans[k]`, or `iREN[k]`.
- **Grant (IDLE only).** Winner `req` is the first eligible CPU searching from `rr_ptr` upward, modulo CPUS.
- **Operation select for the winner.** Priority `dWEN` > coherent `dREN` > `iREN`:
  - `dWEN` → RAMWR.
  - coherent `dREN` → SNOOP; the `ccwrite` value is latched as `rdx`.
  - `iREN` → IFETCH.
- **IDLE.** If nothing is eligible, stay in IDLE with outputs at reset values.
- **SNOOP (exactly 1 cycle).** For every j≠req:
  - `ccwait[j]`=1, `ccsnoopaddr[j]` = block base with word 0.
  - `ccinv[j]` = `rdx`.
  - If any j≠req has `cctrans[j]`: latch `src` = lowest such j, go to C2C. Otherwise go to RAMRD.
- **C2C.** Per word w = `wcnt`; word address A = `{daddr[req][31:WB+2], w, 2'b00}`.
  - `ccwait[src]`=1, `ccsnoopaddr[src]`=A, `ccinv[src]`=`rdx`.
  - `ramWEN`=1, `ramaddr`=A, `ramstore`=`dstore[src]`, `dload[req]`=`dstore[src]`.
- **RAMRD.** `ramREN`=1, `ramaddr`=A, `dload[req]`=`ramload`.
- **RAMWR.** `ramWEN`=1, `ramaddr`=A, `ramstore`=`dstore[req]`. No snoop is issued.
- **IFETCH.** Single word. `ramREN`=1, `ramaddr`=`iaddr[req]`, `iload[req]`=`ramload`.
- **Word progress (all multi-word states).** On `ramstate`==ACCESS: that cycle drive `dwait[req]`=0 and increment `wcnt`. When `wcnt`==WORDS-1, set `wcnt`=0, go to IDLE, set `rr_ptr` = req+1 mod CPUS.
- **RAM states.** FREE, BUSY and ERROR all hold state and counters; no wait is released.
- **Isolation.** Non-granted CPUs always see `iwait`/`dwait`=1 and `dload`/`iload`=0.

## Timing
- **IDLE→SNOOP/RAMWR/IFETCH:** 1 cycle from the request being sampled. Outputs in IDLE are never asserted.
- **Coherent read latency:** 1 (arbitrate) + 1 (SNOOP) + WORDS×(RAM latency) cycles. Each word completes on its ACCESS cycle.
- **Requests dropped mid-transaction:** ignored. The granted transaction runs to completion; caches must hold requests until the final `dwait` low.
- **Simultaneous requests:** exactly one grant per IDLE cycle. A requester losing arbitration is served within CPUS-1 transactions (round-robin bound).
- **Same-cycle write-back and read to the same block from different CPUs:** the pointer order decides; no merging.
- **Async reset mid-transaction:** immediate return to IDLE and reset values; RAM strobes drop in the same cycle.
- **Wrap:** `wcnt` is WB bits wide; `rr_ptr` wraps from CPUS-1 to 0.

## Test plan
- **Fetch:** CPUS=4, RAM latency 2, `iREN[2]`=1, `iaddr[2]`=0x0040 → `ramREN`=1, `ramaddr`=0x0040; `iwait[2]` low exactly one cycle with `iload[2]`=RAM[0x40]; other waits stay 1.
- **Clean coherent read:** `dREN[1]`, `cctrans[1]`, `ccwrite[1]`=0, `daddr`=0x1004, no snoopee responds → SNOOP drives `ccwait` high on CPUs 0, 2, 3 with `ccsnoopaddr`=0x1000 and `ccinv`=0. RAM reads 0x1000 then 0x1004, each with one `dwait[1]` low pulse.
- **Dirty BusRdX:** CPU 0 requests with `ccwrite`=1; CPU 3 asserts `cctrans` → `ccinv[3]`=1. `dload[0]`=`dstore[3]` and `ramWEN` write 0x2000/0x2004 with the same data.
- **Round-robin fairness:** all four CPUs hold `iREN` continuously from reset → grants in order 0, 1, 2, 3, 0.
- **Write-back priority:** CPU 2 asserts `dWEN` and `iREN` together → RAMWR served first, then IFETCH on a later grant.
- **Reset abort:** assert `nRST`=0 during the second C2C word → next edge shows IDLE; `ramWEN`=0, all `ccwait`=0, all waits 1.
